// File: rtl/port_bufid_queue.sv
// Per-port buffer-ID queue: TS and BE classes, strict-priority head, drop report on full class.
// Latency: accepted entry visible at head (and ack/drop pulse) one cycle after the req rising edge.
// Backpressure: none upstream (every request is acked, overflow drops); downstream pops via i_head_rd.
// Optional statistics (drop count, high-water marks) enabled by defining PORT_BUFID_QUEUE_STAT_EN.
module port_bufid_queue #(
    parameter int         TS_DEPTH    = 16,
    parameter int         BE_DEPTH    = 32,
    parameter logic [2:0] TS_TYPE_MAX = 3'd2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [8:0]                iv_pkt_bufid,
    input  logic [2:0]                iv_pkt_type,
    input  logic                      i_pkt_bufid_req,
    output logic                      o_pkt_bufid_ack,
    output logic                      o_head_valid,
    output logic [8:0]                ov_head_bufid,
    output logic [2:0]                ov_head_type,
    input  logic                      i_head_rd,
    output logic                      o_drop_pulse,
    output logic [8:0]                ov_drop_bufid,
`ifdef PORT_BUFID_QUEUE_STAT_EN
    input  logic                      i_stat_clr,
    output logic [15:0]               ov_drop_cnt,
    output logic [$clog2(TS_DEPTH):0] ov_ts_hwm,
    output logic [$clog2(BE_DEPTH):0] ov_be_hwm,
`endif
    output logic [$clog2(TS_DEPTH):0] ov_ts_cnt,
    output logic [$clog2(BE_DEPTH):0] ov_be_cnt
);

    localparam int TS_PW = $clog2(TS_DEPTH);
    localparam int BE_PW = $clog2(BE_DEPTH);

    // Each entry is {bufid, pkt_type}
    logic [11:0]      ts_mem_q [TS_DEPTH];
    logic [11:0]      be_mem_q [BE_DEPTH];

    logic [TS_PW-1:0] ts_wr_ptr_q, ts_wr_ptr_d, ts_rd_ptr_q, ts_rd_ptr_d;
    logic [BE_PW-1:0] be_wr_ptr_q, be_wr_ptr_d, be_rd_ptr_q, be_rd_ptr_d;
    logic [TS_PW:0]   ts_cnt_q, ts_cnt_d;
    logic [BE_PW:0]   be_cnt_q, be_cnt_d;

    logic             req_q;
    logic             ack_q;
    logic             drop_q;
    logic [8:0]       drop_bufid_q;

    logic             accept, is_ts;
    logic             ts_full, be_full, ts_ne, be_ne;
    logic             head_vld, pop, ts_pop, be_pop;
    logic             ts_push, be_push, drop;
    logic [11:0]      head_dat;

    // Request edge detect, class decode, full/empty and pop routing
    always_comb begin
        accept   = i_pkt_bufid_req & ~req_q;
        is_ts    = (iv_pkt_type <= TS_TYPE_MAX);
        ts_full  = (ts_cnt_q == (TS_PW+1)'(TS_DEPTH));
        be_full  = (be_cnt_q == (BE_PW+1)'(BE_DEPTH));
        ts_ne    = (ts_cnt_q != '0);
        be_ne    = (be_cnt_q != '0);
        head_vld = ts_ne | be_ne;
        pop      = i_head_rd & head_vld;
        ts_pop   = pop & ts_ne;
        be_pop   = pop & ~ts_ne;
        // Full is judged on the pre-pop count, so a same-cycle pop never makes room
        ts_push  = accept &  is_ts & ~ts_full;
        be_push  = accept & ~is_ts & ~be_full;
        drop     = accept & (is_ts ? ts_full : be_full);
    end

    // Pointer and occupancy next-state for both classes
    always_comb begin
        ts_wr_ptr_d = ts_wr_ptr_q;
        ts_rd_ptr_d = ts_rd_ptr_q;
        ts_cnt_d    = ts_cnt_q;
        be_wr_ptr_d = be_wr_ptr_q;
        be_rd_ptr_d = be_rd_ptr_q;
        be_cnt_d    = be_cnt_q;
        if (ts_push) ts_wr_ptr_d = ts_wr_ptr_q + TS_PW'(1);
        if (ts_pop)  ts_rd_ptr_d = ts_rd_ptr_q + TS_PW'(1);
        if (be_push) be_wr_ptr_d = be_wr_ptr_q + BE_PW'(1);
        if (be_pop)  be_rd_ptr_d = be_rd_ptr_q + BE_PW'(1);
        case ({ts_push, ts_pop})
            2'b10:   ts_cnt_d = ts_cnt_q + (TS_PW+1)'(1);
            2'b01:   ts_cnt_d = ts_cnt_q - (TS_PW+1)'(1);
            default: ts_cnt_d = ts_cnt_q;
        endcase
        case ({be_push, be_pop})
            2'b10:   be_cnt_d = be_cnt_q + (BE_PW+1)'(1);
            2'b01:   be_cnt_d = be_cnt_q - (BE_PW+1)'(1);
            default: be_cnt_d = be_cnt_q;
        endcase
    end

    // Control state registers with synchronous reset; req_q resets high so a held req is not taken
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_q        <= 1'b1;
            ack_q        <= 1'b0;
            drop_q       <= 1'b0;
            drop_bufid_q <= '0;
            ts_wr_ptr_q  <= '0;
            ts_rd_ptr_q  <= '0;
            ts_cnt_q     <= '0;
            be_wr_ptr_q  <= '0;
            be_rd_ptr_q  <= '0;
            be_cnt_q     <= '0;
        end else begin
            req_q        <= i_pkt_bufid_req;
            ack_q        <= accept;
            drop_q       <= drop;
            drop_bufid_q <= drop ? iv_pkt_bufid : 9'd0;
            ts_wr_ptr_q  <= ts_wr_ptr_d;
            ts_rd_ptr_q  <= ts_rd_ptr_d;
            ts_cnt_q     <= ts_cnt_d;
            be_wr_ptr_q  <= be_wr_ptr_d;
            be_rd_ptr_q  <= be_rd_ptr_d;
            be_cnt_q     <= be_cnt_d;
        end
    end

    // Entry storage; contents need no reset since occupancy qualifies every read
    always_ff @(posedge i_clk) begin
        if (!i_rst && ts_push) ts_mem_q[ts_wr_ptr_q] <= {iv_pkt_bufid, iv_pkt_type};
        if (!i_rst && be_push) be_mem_q[be_wr_ptr_q] <= {iv_pkt_bufid, iv_pkt_type};
    end

    // Strict-priority head select; outputs forced to zero when nothing is queued
    always_comb begin
        head_dat = '0;
        if (ts_ne)      head_dat = ts_mem_q[ts_rd_ptr_q];
        else if (be_ne) head_dat = be_mem_q[be_rd_ptr_q];
    end

    assign o_pkt_bufid_ack = ack_q;
    assign o_drop_pulse    = drop_q;
    assign ov_drop_bufid   = drop_bufid_q;
    assign o_head_valid    = head_vld;
    assign ov_head_bufid   = head_dat[11:3];
    assign ov_head_type    = head_dat[2:0];
    assign ov_ts_cnt       = ts_cnt_q;
    assign ov_be_cnt       = be_cnt_q;

`ifdef PORT_BUFID_QUEUE_STAT_EN
    logic [15:0]    drop_cnt_q, drop_cnt_d;
    logic [TS_PW:0] ts_hwm_q, ts_hwm_d;
    logic [BE_PW:0] be_hwm_q, be_hwm_d;

    // Saturating drop counter and high-water marks; a clear overrides same-cycle updates
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        ts_hwm_d   = ts_hwm_q;
        be_hwm_d   = be_hwm_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
        if (ts_cnt_d > ts_hwm_q)              ts_hwm_d   = ts_cnt_d;
        if (be_cnt_d > be_hwm_q)              be_hwm_d   = be_cnt_d;
        if (i_stat_clr) begin
            drop_cnt_d = '0;
            ts_hwm_d   = '0;
            be_hwm_d   = '0;
        end
    end

    // Statistics registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_cnt_q <= '0;
            ts_hwm_q   <= '0;
            be_hwm_q   <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            ts_hwm_q   <= ts_hwm_d;
            be_hwm_q   <= be_hwm_d;
        end
    end

    assign ov_drop_cnt = drop_cnt_q;
    assign ov_ts_hwm   = ts_hwm_q;
    assign ov_be_hwm   = be_hwm_q;
`endif

endmodule
